// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue controller feeding the UART transmitter.
// Optional drop counter output enabled by defining UART_TXQ_DROP_CNT_EN.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf_tick,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_done_tick,
    output logic                  busy
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Full blocks writes even if a pop lands on the same edge.
    always_comb begin
        push       = wr_en && !full;
        drop       = wr_en && full;
        pop        = (state == S_IDLE) && !empty;
        count_next = count + CW'(push) - CW'(pop);
    end

    // Storage is not reset; contents are simply discarded with the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            ovf_tick <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            count    <= count_next;
            level    <= count_next;
            full     <= (count_next == CW'(DEPTH));
            empty    <= (count_next == '0);
            ovf_tick <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Issue one byte at a time, then wait for the transmitter's done tick.
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        tx_data  <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + 1'b1;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tx_valid <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_DROP_CNT_EN
    // Saturating count of dropped writes, stepping with ovf_tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized and directed bench for uart_tx_fifo against a queue-based model.
module tb_uart_tx_fifo;

    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 1 << DL;

    logic          clk;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [DL:0]   level;
    logic          ovf_tick;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_done_tick;
    logic          busy;
`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .ovf_tick     (ovf_tick),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
`ifdef UART_TXQ_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued bytes, in-flight flag, last issued byte.
    logic [7:0] q [$];
    logic       m_busy;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovf;
    int         m_drop;
    int         n_issued;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic we, input logic [7:0] d, input logic dn, input logic r);
        bit issue;
        bit done_ok;
        bit drop;
        if (r) begin
            q.delete();
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
            m_drop  = 0;
            return;
        end
        issue   = !m_busy && (q.size() > 0);
        done_ok = m_busy && !m_valid && dn;
        drop    = we && (q.size() == DEPTH);
        if (issue) begin
            m_data = q.pop_front();
            n_issued++;
        end
        m_valid = issue;
        if (issue)        m_busy = 1'b1;
        else if (done_ok) m_busy = 1'b0;
        if (we && !drop) q.push_back(d);
        m_ovf = drop;
        if (drop && m_drop != 255) m_drop++;
    endtask

    task automatic check_all();
        check_eq("tx_valid", 32'(tx_valid), 32'(m_valid));
        check_eq("busy",     32'(busy),     32'(m_busy));
        check_eq("tx_data",  32'(tx_data),  32'(m_data));
        check_eq("level",    32'(level),    32'(q.size()));
        check_eq("full",     32'(full),     32'(q.size() == DEPTH));
        check_eq("empty",    32'(empty),    32'(q.size() == 0));
        check_eq("ovf_tick", 32'(ovf_tick), 32'(m_ovf));
`ifdef UART_TXQ_DROP_CNT_EN
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // Drive at negedge, model the posedge, check at the following negedge.
    task automatic cycle(input logic we, input logic [7:0] d, input logic dn, input logic r);
        wr_en        = we;
        wr_data      = d;
        tx_done_tick = dn;
        rst          = r;
        @(posedge clk);
        model_step(we, d, dn, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Let the transmitter finish the in-flight byte.
    task automatic done_pulse();
        idle(2);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int wr_pct;
        wr_en = 0; wr_data = 0; tx_done_tick = 0; rst = 1;
        m_busy = 0; m_valid = 0; m_data = 0; m_ovf = 0; m_drop = 0; n_issued = 0;
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Single byte
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t1_valid", 32'(tx_valid), 32'd1);
        check_eq("t1_data",  32'(tx_data),  32'hA5);
        done_pulse();
        check_eq("t1_busy",  32'(busy),     32'd0);

        // Spurious done while idle/empty, then during the issue cycle
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t4_busy", 32'(busy), 32'd1);
        done_pulse();

        // Burst of 17, then overflow with 8'hEE
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check_eq("t2_full",  32'(full),  32'd1);
        check_eq("t2_level", 32'(level), 32'd16);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("t3_ovf", 32'(ovf_tick), 32'd1);

        // Full + pop on the same edge
        idle(1);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check_eq("t5_ovf", 32'(ovf_tick), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("t5_level", 32'(level), 32'd15);
        for (int i = 0; i < 16; i++) done_pulse();
        idle(2);

        // Reset mid-transfer
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t6_busy", 32'(busy), 32'd0);
        idle(6);

        // Randomized traffic
        wr_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) wr_pct = (i % 1500 == 0) ? 95 : ((i % 1000 == 0) ? 20 : 60);
            cycle(($urandom_range(0, 99) < wr_pct) ? 1'b1 : 1'b0,
                  8'($urandom()),
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
